// File: rtl/sys_clock_reset_gen.sv
// sys_clock_reset_gen
// Divides the crystal clock into phi1/phi2/clk_out, conditions the external
// active-low RESET IN into a phase-aligned reset_out, and sequences the
// machine-cycle T-states (TRESET, T1, T2, T3), driving ale throughout T1.
module sys_clock_reset_gen #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       x1,
    input  logic       reset,
    input  logic       x2,
    input  logic       resetn_in,
    output logic       phi1,
    output logic       phi2,
    output logic       clk_out,
    output logic       reset_out,
    output logic       ale,
    output logic [1:0] t_state
);

    typedef enum logic [1:0] {
        TRESET = 2'd0,
        T1     = 2'd1,
        T2     = 2'd2,
        T3     = 2'd3
    } tstate_t;

    // x2 is the complementary crystal pin; kept only for pin compatibility
    logic x2_unused;
    assign x2_unused = x2;

    logic                   q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs;
    logic                   reset_out_next;
    tstate_t                state;
    tstate_t                state_next;
    logic                   ale_next;

    // The oldest synchronizer stage is the usable, metastability-filtered level
    assign rs = sync_q[SYNC_STAGES-1];

    // Divide-by-two toggle flop; phi2 has its own flop so it is never gated
    always_ff @(posedge x1) begin
        if (reset) begin
            q    <= 1'b0;
            phi2 <= 1'b1;
        end else begin
            q    <= ~q;
            phi2 <= q;
        end
    end

    assign phi1    = q;
    assign clk_out = q;

    // Synchronizer chain for the asynchronous RESET IN pin
    always_ff @(posedge x1) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], resetn_in};
        end
    end

    // Release only when q is about to rise, so the core leaves reset on a phi1 edge
    always_comb begin
        reset_out_next = reset_out;
        if (!rs) begin
            reset_out_next = 1'b1;
        end else if (!q) begin
            reset_out_next = 1'b0;
        end
    end

    // reset_out register
    always_ff @(posedge x1) begin
        if (reset) begin
            reset_out <= 1'b1;
        end else begin
            reset_out <= reset_out_next;
        end
    end

    // T-state register
    always_ff @(posedge x1) begin
        if (reset) begin
            state <= TRESET;
        end else begin
            state <= state_next;
        end
    end

    // Next state: enter T1 on release, then advance on every phi1 rising edge
    always_comb begin
        state_next = state;
        if (reset_out_next) begin
            state_next = TRESET;
        end else if (reset_out) begin
            state_next = T1;
        end else if (!q) begin
            case (state)
                T1:      state_next = T2;
                T2:      state_next = T3;
                T3:      state_next = T1;
                default: state_next = T1;
            endcase
        end
    end

    // ale is registered from the next state so it lines up exactly with T1
    always_comb begin
        ale_next = (state_next == T1);
    end

    // ale register
    always_ff @(posedge x1) begin
        if (reset) begin
            ale <= 1'b0;
        end else begin
            ale <= ale_next;
        end
    end

    assign t_state = state;

endmodule

// File: tb/tb_sys_clock_reset_gen.sv
// Bench for sys_clock_reset_gen: table of per-edge vectors for power-on,
// divider, release and sequencing, then hand-written corner-case sequences.
module tb_sys_clock_reset_gen;

    logic       x1;
    logic       reset;
    logic       resetn_in;
    logic       phi1;
    logic       phi2;
    logic       clk_out;
    logic       reset_out;
    logic       ale;
    logic [1:0] t_state;

    int checks;
    int errors;

    typedef struct {
        logic       rst;
        logic       rn;
        logic       p1;
        logic       ro;
        logic [1:0] t;
        logic       a;
        string      name;
    } vec_t;

    vec_t       tbl[$];
    logic [6:0] exp_q[$];

    sys_clock_reset_gen #(.SYNC_STAGES(2)) dut (
        .x1        (x1),
        .reset     (reset),
        .x2        (~x1),
        .resetn_in (resetn_in),
        .phi1      (phi1),
        .phi2      (phi2),
        .clk_out   (clk_out),
        .reset_out (reset_out),
        .ale       (ale),
        .t_state   (t_state)
    );

    initial begin
        x1 = 1'b0;
        forever #5 x1 = ~x1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Drive one edge's inputs, queue its expected outputs, then compare after the edge
    task automatic step(input logic r, input logic rn, input logic p1, input logic ro,
                        input logic [1:0] t, input logic a, input string name);
        logic [6:0] got;
        logic [6:0] want;
        @(negedge x1);
        reset     = r;
        resetn_in = rn;
        exp_q.push_back({p1, ~p1, p1, ro, t, a});
        @(posedge x1);
        #1;
        got  = {phi1, phi2, clk_out, reset_out, t_state, ale};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: {phi1,phi2,clk_out,reset_out,t_state,ale} got %b want %b",
                     name, $time, got, want);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        resetn_in = 1'b0;

        // Power-on: three reset edges
        for (int i = 0; i < 3; i++)
            tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, "power_on"});
        // Divider free-running while RESET IN is held low
        for (int i = 0; i < 20; i++)
            tbl.push_back('{1'b0, 1'b0, (i % 2 == 0), 1'b1, 2'd0, 1'b0, "divider"});
        // Release: rs high after two edges, reset_out drops on the next q rise
        for (int j = 0; j < 80; j++) begin
            if (j < 2) begin
                tbl.push_back('{1'b0, 1'b1, (j % 2 == 0), 1'b1, 2'd0, 1'b0, "release_wait"});
            end else begin
                logic [1:0] tt;
                tt = 2'(((j - 2) / 2) % 3 + 1);
                tbl.push_back('{1'b0, 1'b1, (j % 2 == 0), 1'b0, tt, (tt == 2'd1), "sequence"});
            end
        end

        foreach (tbl[i])
            step(tbl[i].rst, tbl[i].rn, tbl[i].p1, tbl[i].ro, tbl[i].t, tbl[i].a, tbl[i].name);

        // Sequence left off at second edge of T3; continue into T1, T2
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, "seq_t1a");
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, "seq_t1b");
        // RESET IN drops as T2 begins; asserted two edges later, divider keeps going
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, "mid_t2a");
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, "mid_t2b");
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "mid_assert");
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, "mid_hold_a");
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "mid_hold_b");
        // Release on the opposite phase: three-edge latency
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, "late_rel_k");
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, "late_rel_k1");
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, "late_rel_k2");
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, "late_rel_k3");
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, "late_t1");
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, "late_t2a");
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, "late_t2b");
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, "late_t3");
        // Master reset pulse during T3 overrides everything on that edge
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, "master_reset");
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, "post_rst_a");
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, "post_rst_b");
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, "post_rst_rel");
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, "post_rst_t1");
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, "post_rst_t2");
        // RESET IN drops during T2; release window never opens again
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, "drop_again_a");
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, "drop_again_b");
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, "drop_again_assert");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
